node_fifo_bank: RTL and testbench

Per-node weight/input buffering stage directly downstream of the address arbiter.
- Takes the arbiter's fetch_en, wr_en one-hot and all_done, plus the memory read-data bus.
- Aligns wr_en with the memory's read latency and writes each returned word into the selected node's FIFO.
- Returns a credit-safe full to the arbiter. Each neural node drains its own FIFO through a registered read port.

---
 rtl/nn_pkg.sv | 8 +
 rtl/node_fifo.sv | 73 +++++++
 rtl/node_fifo_bank.sv | 114 +++++++++++
 tb/tb_node_fifo_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared defaults for the address arbiter, the node FIFO bank and the node datapath.
package nn_pkg;

    localparam int unsigned NN_DATA_WIDTH = 16;
    localparam int unsigned NN_NUM_NODES  = 4;
    localparam int unsigned NN_ADDR_WIDTH = 10;

endpackage

// File: rtl/node_fifo.sv
// Single synchronous FIFO with occupancy count, registered read port and error pulses.
module node_fifo
    import nn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [PW:0]           count,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  is_empty, is_full, do_rd, do_wr;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (PW+1)'(DEPTH));
    assign do_rd    = rd && !is_empty;
    // A same-cycle pop frees a slot, so a write to a full FIFO still lands.
    assign do_wr    = wr && (!is_full || do_rd);

    always_comb begin
        count_d = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= do_rd;
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign overflow  = wr && !do_wr;
    assign underflow = rd && is_empty;

endmodule

// File: rtl/node_fifo_bank.sv
// Per-node buffering behind the address arbiter: latency alignment, credit-safe full, drain status.
module node_fifo_bank
    import nn_pkg::*;
#(
    parameter int unsigned NUM_NODES  = NN_NUM_NODES,
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_en,
    input  logic [NUM_NODES-1:0]            wr_en,
    input  logic                            all_done,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    output logic                            full,
    input  logic [NUM_NODES-1:0]            rd_en,
    output logic [NUM_NODES*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_NODES-1:0]            rd_valid,
    output logic [NUM_NODES-1:0]            empty,
    output logic                            drain_done,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int unsigned IW = $clog2(RD_LATENCY + 2);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = CW + 1;

    logic [NUM_NODES-1:0] pipe_q [RD_LATENCY];
    logic [NUM_NODES-1:0] issue, pipe_out;
    logic [IW-1:0]        inflight_q [NUM_NODES];
    logic [IW-1:0]        inflight_d [NUM_NODES];
    logic [CW-1:0]        count [NUM_NODES];
    logic [NUM_NODES-1:0] ovf, unf;
    logic                 ovf_q, unf_q, drain_q;
    logic                 drain_d;

    assign issue    = fetch_en ? wr_en : '0;
    assign pipe_out = pipe_q[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= issue;
            for (int k = 1; k < RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NODES; i++) begin
            inflight_d[i] = inflight_q[i];
            unique case ({issue[i], pipe_out[i]})
                2'b10:   inflight_d[i] = inflight_q[i] + 1'b1;
                2'b01:   inflight_d[i] = inflight_q[i] - 1'b1;
                default: inflight_d[i] = inflight_q[i];
            endcase
        end
    end

    // Threshold of DEPTH-1 leaves room for the arbiter's one blind issue after full rises.
    always_comb begin
        full = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if ((RW'(count[i]) + RW'(inflight_q[i])) >= RW'(DEPTH - 1)) full = 1'b1;
        end
    end

    always_comb begin
        drain_d = all_done && (&empty);
        for (int i = 0; i < NUM_NODES; i++) begin
            if (inflight_q[i] != '0) drain_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NODES; i++) inflight_q[i] <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_NODES; i++) inflight_q[i] <= inflight_d[i];
            ovf_q   <= ovf_q | (|ovf);
            unf_q   <= unf_q | (|unf);
            drain_q <= drain_d;
        end
    end

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_fifo
        node_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr        (pipe_out[g]),
            .wr_data   (mem_data),
            .rd        (rd_en[g]),
            .rd_data   (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid  (rd_valid[g]),
            .count     (count[g]),
            .empty     (empty[g]),
            .overflow  (ovf[g]),
            .underflow (unf[g])
        );
    end

    assign drain_done    = drain_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_node_fifo_bank.sv
// Directed self-checking bench for node_fifo_bank (4 nodes, 16-bit words, depth 8, latency 1).
module tb_node_fifo_bank;

    localparam int unsigned NN = 4;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_en = 1'b0;
    logic [NN-1:0]     wr_en = '0;
    logic              all_done = 1'b0;
    logic [DW-1:0]     mem_data = '0;
    logic              full;
    logic [NN-1:0]     rd_en = '0;
    logic [NN*DW-1:0]  rd_data;
    logic [NN-1:0]     rd_valid;
    logic [NN-1:0]     empty;
    logic              drain_done;
    logic              overflow_err;
    logic              underflow_err;

    int tests = 0;
    int fails = 0;

    node_fifo_bank #(
        .NUM_NODES  (NN),
        .DATA_WIDTH (DW),
        .DEPTH      (8),
        .RD_LATENCY (1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .wr_en         (wr_en),
        .all_done      (all_done),
        .mem_data      (mem_data),
        .full          (full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .drain_done    (drain_done),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        fetch_en = 1'b0;
        wr_en    = '0;
        rd_en    = '0;
        all_done = 1'b0;
        mem_data = '0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       issued;
        logic     arb_go;
        logic     fetched_last;
        int       got [NN];
        logic [DW-1:0] w;

        // Reset values
        #3;
        check("rst_full", full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_empty", empty, 4'hF);
        check("rst_drain", drain_done, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_unf", underflow_err, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single write to node 0, then read it back
        fetch_en = 1'b1; wr_en = 4'b0001;
        tick();
        fetch_en = 1'b0; wr_en = '0; mem_data = 16'hA5A5;
        check("single_pre_empty", empty, 4'hF);
        tick();
        mem_data = '0;
        check("single_empty0", empty, 4'hE);
        rd_en = 4'b0001;
        tick();
        rd_en = '0;
        check("single_valid", rd_valid, 4'b0001);
        check("single_data", rd_data[15:0], 16'hA5A5);
        check("single_empty_after", empty, 4'hF);
        tick();
        check("single_valid_drop", rd_valid, 0);
        check("single_data_hold", rd_data[15:0], 16'hA5A5);

        // Fill node 2 via an arbiter model that sees full one cycle late
        issued = 0; arb_go = 1'b1; fetched_last = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("fill_full_c%0d", c), full, (issued >= 7));
            mem_data = fetched_last ? DW'(16'h2000 + issued - 1) : '0;
            fetch_en = arb_go;
            wr_en    = arb_go ? 4'b0100 : 4'b0000;
            fetched_last = arb_go;
            if (arb_go) issued++;
            arb_go = !full;
            tick();
        end
        fetch_en = 1'b0; wr_en = '0; mem_data = '0;
        check("fill_ovf", overflow_err, 0);
        check("fill_empty", empty, 4'hB);
        for (int k = 0; k < 8; k++) begin
            rd_en = 4'b0100;
            tick();
            check($sformatf("fill_valid_%0d", k), rd_valid, 4'b0100);
            check($sformatf("fill_data_%0d", k), rd_data[47:32], 16'h2000 + k);
        end
        rd_en = '0;
        tick();
        check("fill_drained_empty", empty, 4'hF);
        check("fill_drained_full", full, 0);

        // Round-robin 32 addresses, all nodes reading every cycle
        do_reset();
        for (int n = 0; n < NN; n++) got[n] = 0;
        rd_en = 4'hF;
        for (int c = 0; c < 40; c++) begin
            fetch_en = (c < 32);
            wr_en    = (c < 32) ? (4'b0001 << (c % 4)) : 4'b0000;
            mem_data = (c >= 1 && c <= 32) ? DW'(c - 1) : '0;
            all_done = (c >= 32);
            tick();
            for (int n = 0; n < NN; n++) begin
                if (rd_valid[n]) begin
                    check($sformatf("rr_n%0d_w%0d", n, got[n]), rd_data[n*DW +: DW],
                          n + 4 * got[n]);
                    got[n]++;
                end
            end
        end
        rd_en = '0;
        for (int n = 0; n < NN; n++) check($sformatf("rr_count_n%0d", n), got[n], 8);
        check("rr_drain_done", drain_done, 1);
        check("rr_ovf", overflow_err, 0);
        all_done = 1'b0;
        tick();
        check("rr_drain_drop", drain_done, 0);

        // Forced overflow on node 0 with full ignored
        do_reset();
        for (int k = 0; k < 10; k++) begin
            fetch_en = (k < 9);
            wr_en    = (k < 9) ? 4'b0001 : 4'b0000;
            mem_data = (k == 9) ? 16'hDEAD : (k >= 1) ? DW'(16'h4000 + k - 1) : '0;
            tick();
            if (k == 8) check("ovf_before", overflow_err, 0);
        end
        fetch_en = 1'b0; wr_en = '0; mem_data = '0;
        check("ovf_set", overflow_err, 1);
        for (int k = 0; k < 8; k++) begin
            rd_en = 4'b0001;
            tick();
            check($sformatf("ovf_data_%0d", k), rd_data[15:0], 16'h4000 + k);
        end
        rd_en = '0;
        tick();
        check("ovf_sticky", overflow_err, 1);
        check("ovf_empty", empty, 4'hF);

        // Underflow on node 1, then simultaneous write+read at count 8
        do_reset();
        rd_en = 4'b0010;
        tick();
        rd_en = '0;
        check("unf_valid", rd_valid, 0);
        check("unf_set", underflow_err, 1);
        for (int k = 0; k < 9; k++) begin
            fetch_en = (k < 8);
            wr_en    = (k < 8) ? 4'b0010 : 4'b0000;
            mem_data = (k >= 1) ? DW'(16'h5000 + k - 1) : '0;
            tick();
        end
        fetch_en = 1'b1; wr_en = 4'b0010; mem_data = '0;
        tick();
        fetch_en = 1'b0; wr_en = '0; mem_data = 16'h50AA; rd_en = 4'b0010;
        tick();
        mem_data = '0;
        check("wr_rd_valid", rd_valid, 4'b0010);
        check("wr_rd_data", rd_data[31:16], 16'h5000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            w = (k == 8) ? 16'h50AA : DW'(16'h5000 + k);
            check($sformatf("wr_rd_data_%0d", k), rd_data[31:16], w);
        end
        rd_en = '0;
        tick();
        check("wr_rd_ovf", overflow_err, 0);
        check("wr_rd_empty", empty, 4'hF);

        // Mid-stream reset with count=5 and one word in flight on node 3
        do_reset();
        all_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fetch_en = 1'b1; wr_en = 4'b1000;
            mem_data = (k >= 1) ? DW'(16'h6000 + k - 1) : '0;
            tick();
        end
        fetch_en = 1'b0; wr_en = '0; mem_data = 16'h6005;
        check("mid_pre_empty", empty, 4'h7);
        #1;
        rst = 1'b0;
        #1;
        check("mid_empty", empty, 4'hF);
        check("mid_full", full, 0);
        check("mid_drain", drain_done, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("mid_post_empty", empty, 4'hF);
        rd_en = 4'b1000;
        tick();
        rd_en = '0;
        check("mid_post_valid", rd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
